// File: rtl/booth4_mul_sched.sv
// Sequential radix-4 Booth multiplier shared by two round-robin requesters.
// One Booth digit is retired per clock; the signed product is returned with its owner id.
module booth4_mul_sched #(
  parameter int TAM = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [TAM-1:0]   a0,
  input  logic [TAM-1:0]   b0,
  input  logic             req1,
  input  logic [TAM-1:0]   a1,
  input  logic [TAM-1:0]   b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             valid,
  output logic             id,
  output logic [2*TAM-1:0] S
);

  localparam int PW   = 2 * TAM;
  localparam int NDIG = TAM / 2;
  localparam int JW   = $clog2(NDIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  p_q, p_d;
  logic [PW-1:0]  md_q, md_d;
  logic [TAM:0]   mr_q, mr_d;
  logic [JW-1:0]  j_q, j_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [PW-1:0]  s_q, s_d;
  logic           valid_q, valid_d;

  logic           grant0, grant1;
  logic [PW-1:0]  md2;
  logic [PW-1:0]  addend;

  // On a tie the requester that did not win last time is served.
  assign grant0 = req0 && (!req1 || last_q);
  assign grant1 = req1 && (!req0 || !last_q);

  // md_q and mr_q are shifted by one digit each RUN cycle, so the current
  // digit is always mr_q[2:0] and the addend is already weighted by 4^j.
  assign md2 = {md_q[PW-2:0], 1'b0};

  always_comb begin
    addend = '0;
    unique case (mr_q[2:0])
      3'b001, 3'b010: addend = md_q;
      3'b011:         addend = md2;
      3'b100:         addend = PW'(0) - md2;
      3'b101, 3'b110: addend = PW'(0) - md_q;
      default:        addend = '0;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    p_d     = p_q;
    md_d    = md_q;
    mr_d    = mr_q;
    j_d     = j_q;
    last_d  = last_q;
    id_d    = id_q;
    s_d     = s_q;
    valid_d = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          ack0    = grant0;
          ack1    = grant1;
          md_d    = grant1 ? {{TAM{a1[TAM-1]}}, a1} : {{TAM{a0[TAM-1]}}, a0};
          mr_d    = grant1 ? {b1, 1'b0} : {b0, 1'b0};
          p_d     = '0;
          j_d     = '0;
          id_d    = grant1;
          last_d  = grant1;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d  = p_q + addend;
        md_d = {md_q[PW-3:0], 2'b00};
        mr_d = {2'b00, mr_q[TAM:2]};
        j_d  = j_q + 1'b1;
        if (j_q == JW'(NDIG - 1)) state_d = DONE;
      end
      DONE: begin
        s_d     = p_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      md_q    <= '0;
      mr_q    <= '0;
      j_q     <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
      j_q     <= j_d;
      last_q  <= last_d;
      id_q    <= id_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign id    = id_q;
  assign S     = s_q;

endmodule

// File: tb/tb_booth4_mul_sched.sv
// Self-checking bench for booth4_mul_sched: directed scenarios plus randomized
// back-to-back traffic compared against a plain-arithmetic reference model.
module tb_booth4_mul_sched;

  localparam int TAM = 8;
  localparam int PW  = 2 * TAM;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [TAM-1:0] a0, b0, a1, b1;
  logic          ack0, ack1, busy, valid, id;
  logic [PW-1:0] S;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_m;

  booth4_mul_sched #(.TAM(TAM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy),
    .valid(valid), .id(id), .S(S)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] prod(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[PW-1:0];
  endfunction

  function automatic int model_winner(input bit r0, input bit r1);
    if (r0 && r1) return last_m ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with requests applied while the DUT is idle. Returns at
  // the negedge of the valid cycle, so the caller can launch the next request.
  task automatic run_op(input int w, input bit scr);
    logic [PW-1:0] exp_s;
    int edges;
    #1;
    exp_s = (w == 1) ? prod(a1, b1) : prod(a0, b0);
    check("ack0_grant", 32'(ack0), 32'(w == 0));
    check("ack1_grant", 32'(ack1), 32'(w == 1));
    check("busy_idle", 32'(busy), 32'd0);
    last_m = (w == 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_run", 32'(busy), 32'd1);
    edges = 0;
    while (!valid && edges < 20) begin
      check("acks_busy", 32'({ack0, ack1}), 32'd0);
      if (scr) begin
        a0 = TAM'($urandom); b0 = TAM'($urandom);
        a1 = TAM'($urandom); b1 = TAM'($urandom);
        req0 = 1'($urandom); req1 = 1'($urandom);
      end
      step();
      edges++;
    end
    check("valid_seen", 32'(valid), 32'd1);
    check("latency", 32'(edges), 32'(TAM / 2 + 1));
    check("S", 32'(S), 32'(exp_s));
    check("id", 32'(id), 32'(w));
    check("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    rst_n = 1'b1;
    step();

    // 7 * 3, then confirm valid is a single pulse and S/id hold
    req0 = 1'b1; a0 = 8'd7; b0 = 8'd3;
    run_op(0, 1'b0);
    check("S_7x3", 32'(S), 32'h0015);
    req0 = 1'b0;
    step();
    check("valid_pulse", 32'(valid), 32'd0);
    check("S_hold", 32'(S), 32'h0015);
    check("id_hold", 32'(id), 32'd0);

    // extreme corner (-128)*(-128)
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
    run_op(1, 1'b0);
    check("S_min_sq", 32'(S), 32'h4000);
    req1 = 1'b0;
    step();

    // -128*127 then 0*-1 launched in the valid cycle
    req0 = 1'b1; a0 = 8'h80; b0 = 8'h7F;
    run_op(0, 1'b0);
    check("S_min_max", 32'(S), 32'hC080);
    a0 = 8'd0; b0 = 8'hFF;
    run_op(0, 1'b0);
    check("S_zero", 32'(S), 32'h0000);
    req0 = 1'b0;
    step();

    // both requesters held from reset: grants alternate 0,1,0
    rst_n = 1'b0;
    last_m = 1'b1;
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
    req1 = 1'b1; a1 = 8'hFD; b1 = 8'd4;
    step();
    rst_n = 1'b1;
    run_op(model_winner(1'b1, 1'b1), 1'b0);
    check("S_rr0", 32'(S), 32'h0019);
    run_op(model_winner(1'b1, 1'b1), 1'b0);
    check("S_rr1", 32'(S), 32'hFFF4);
    check("id_rr1", 32'(id), 32'd1);
    run_op(model_winner(1'b1, 1'b1), 1'b0);
    check("S_rr2", 32'(S), 32'h0019);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // reset two cycles into RUN aborts the operation
    req0 = 1'b1; a0 = 8'd9; b0 = 8'd9;
    #1;
    check("ack0_abort", 32'(ack0), 32'd1);
    step();
    req0 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    last_m = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_valid", 32'(valid), 32'd0);
    end
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd2;
    run_op(0, 1'b0);
    check("S_2x2", 32'(S), 32'h0004);
    req0 = 1'b0;
    step();

    // operand and request churn during RUN must not disturb 6*-7
    req0 = 1'b1; a0 = 8'd6; b0 = 8'hF9;
    run_op(0, 1'b1);
    check("S_6xm7", 32'(S), 32'hFFD6);
    req0 = 1'b0; req1 = 1'b1; a1 = 8'd3; b1 = 8'hFB;
    run_op(model_winner(1'b0, 1'b1), 1'b0);
    check("S_3xm5", 32'(S), 32'hFFF1);

    // randomized back-to-back traffic
    for (int k = 0; k < 40; k++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      req0 = r0; req1 = r1;
      a0 = TAM'($urandom); b0 = TAM'($urandom);
      a1 = TAM'($urandom); b1 = TAM'($urandom);
      if (k % 8 == 0) begin a0 = 8'h80; b0 = 8'h80; a1 = 8'h80; b1 = 8'h7F; end
      run_op(model_winner(r0, r1), 1'($urandom));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("final_valid", 32'(valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
